// File: rtl/mult_unit.sv
// Sequential 32x32 shift-add multiplier for mult/multu, producing HI/LO.
// All arithmetic, including sign fix-up, goes through one 32-bit ripple-carry adder.

module add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[32];
    end

endmodule

module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, NEGLO, NEGHI} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] mc;
    logic [31:0] acc;
    logic [31:0] q;
    logic [4:0]  cnt;
    logic        neg;
    logic        c;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] sum;
    logic        cout;
    logic [31:0] abs_a;
    logic        neg_b;

    add u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == 5'd31) next_state = NEGLO;
            NEGLO:   next_state = NEGHI;
            NEGHI:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // While idle the adder forms -a so the magnitude is ready at the accept edge.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            IDLE: begin
                add_a   = ~a;
                add_cin = 1'b1;
            end
            RUN: begin
                add_a = acc;
                add_b = q[0] ? mc : 32'd0;
            end
            NEGLO: begin
                add_a   = neg ? ~q : q;
                add_cin = neg;
            end
            NEGHI: begin
                add_a = neg ? ~acc : acc;
                add_b = {31'd0, neg & c};
            end
            default: ;
        endcase
    end

    assign abs_a = (sgn & a[31]) ? sum : a;
    assign neg_b = sgn & b[31];
    assign busy  = (state != IDLE);

    // The adder is busy with |a| at accept, so |b| = ~b + 1 is taken as q = ~b with
    // acc preloaded to |a|: after 32 shifts that preload lands as +|a| in the product.
    always_ff @(posedge clk) begin
        if (reset) begin
            mc   <= '0;
            acc  <= '0;
            q    <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
            c    <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mc  <= abs_a;
                        q   <= neg_b ? ~b : b;
                        acc <= neg_b ? abs_a : 32'd0;
                        neg <= sgn & (a[31] ^ b[31]);
                        cnt <= '0;
                    end
                end
                RUN: begin
                    {acc, q} <= {cout, sum, q[31:1]};
                    cnt      <= cnt + 5'd1;
                end
                NEGLO: begin
                    q <= sum;
                    c <= cout;
                end
                NEGHI: begin
                    hi   <= sum;
                    lo   <= q;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: scoreboard of reference products, latency,
// busy interference, reset abort and back-to-back handshakes.

module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    mult_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic [63:0]        ux;
        logic [63:0]        uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (s) return sx * sy;
        return ux * uy;
    endfunction

    // Pulse start for one cycle; returns at the falling edge after the accept edge.
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sgn = s; start = 1'b1;
        sb.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
        reset = 1'b0;
    endtask

    task automatic run_table(input string name, input logic [31:0] xs[], input logic [31:0] ys[], input logic s);
        int          cycles;
        bit          seen;
        logic [63:0] exp;
        for (int i = 0; i < xs.size(); i++) begin
            launch(xs[i], ys[i], s);
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy[%0d]: got %b expected 1", name, i, busy); end
            wait_done(cycles, seen);
            checks++;
            if (!seen || cycles != 34) begin
                errors++; $display("[TB] FAIL %s_latency[%0d]: got %0d (seen=%b) expected 34", name, i, cycles, seen);
            end
            exp = sb.pop_front();
            checks++;
            if ({hi, lo} !== exp) begin
                errors++; $display("[TB] FAIL %s_result[%0d]: got %h_%h expected %h_%h", name, i, hi, lo, exp[63:32], exp[31:0]);
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_at_done[%0d]: got %b expected 0", name, i, busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_width[%0d]: got %b expected 0", name, i, done); end
        end
    endtask

    task automatic test_unsigned;
        logic [31:0] xs[] = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, $urandom(), $urandom()};
        logic [31:0] ys[] = '{32'd6, 32'hFFFF_FFFF, 32'h1234_5678, 32'd2, $urandom(), $urandom()};
        run_table("unsigned", xs, ys, 1'b0);
    endtask

    task automatic test_signed;
        logic [31:0] xs[] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd5, $urandom()};
        logic [31:0] ys[] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFF9, $urandom()};
        run_table("signed", xs, ys, 1'b1);
    endtask

    task automatic test_busy_interference;
        int          done_count = 0;
        int          first_cyc = 0;
        logic [63:0] exp;
        launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (done_count == 1) begin
                    first_cyc = cyc;
                    exp = sb.pop_front();
                    checks++;
                    if ({hi, lo} !== exp) begin
                        errors++; $display("[TB] FAIL busy_result: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
                    end
                end
            end
            if (cyc == 5 || cyc == 20) begin
                a = $urandom(); b = $urandom(); sgn = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL busy_done_count: got %0d expected 1", done_count); end
        checks++; if (first_cyc != 34) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected 34", first_cyc); end
    endtask

    task automatic test_reset_mid_op;
        int          done_count = 0;
        int          cycles;
        bit          seen;
        logic [63:0] exp;
        launch(32'd7, 32'd6, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("[TB] FAIL abort_hilo: got %h_%h expected 0_0", hi, lo); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_count); end

        reset = 1'b1; start = 1'b1; a = 32'd5; b = 32'd5; sgn = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_wins_busy: got %b expected 0", busy); end
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL reset_wins_done: got %0d pulses expected 0", done_count); end

        launch(32'd2, 32'd3, 1'b0);
        wait_done(cycles, seen);
        checks++;
        if (!seen || cycles != 34) begin
            errors++; $display("[TB] FAIL after_abort_latency: got %0d (seen=%b) expected 34", cycles, seen);
        end
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || lo !== 32'd6) begin
            errors++; $display("[TB] FAIL after_abort_result: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        int          cycles;
        bit          seen;
        bit          held = 1'b1;
        logic [63:0] exp;
        launch(32'd7, 32'd6, 1'b0);
        wait_done(cycles, seen);
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL b2b_first_done: got no done expected done after 34 cycles");
        end
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            errors++; $display("[TB] FAIL b2b_first_result: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
        end
        a = 32'd9; b = 32'd9; sgn = 1'b0; start = 1'b1;
        sb.push_back(model(32'd9, 32'd9, 1'b0));
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_busy: got %b expected 1", busy); end
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if ({hi, lo} !== 64'd42) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("[TB] FAIL b2b_hold: got a change before done expected 42 held"); end
        checks++;
        if (!seen || cycles != 34) begin
            errors++; $display("[TB] FAIL b2b_latency: got %0d (seen=%b) expected 34", cycles, seen);
        end
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || lo !== 32'h51) begin
            errors++; $display("[TB] FAIL b2b_second_result: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
        end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        test_reset;
        test_unsigned;
        test_signed;
        test_busy_interference;
        test_reset_mid_op;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
